// File: rtl/mcu_stream_select.sv
// MCU selector: snapshots one of NUM_MCU decoded BLK x BLK MCUs on a request
// handshake, then streams it out one row (or column) per beat with backpressure.
module mcu_stream_select #(
    parameter int NUM_MCU = 28,
    parameter int BLK     = 8,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 11
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [NUM_MCU-1:0][BLK-1:0][BLK-1:0][DATA_W-1:0]   mcu_in,
    input  logic                                               req_valid,
    output logic                                               req_ready,
    input  logic [SEL_W-1:0]                                   req_sel,
    input  logic                                               req_col,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [BLK-1:0][DATA_W-1:0]                         out_data,
    output logic [$clog2(BLK)-1:0]                             out_idx,
    output logic                                               out_last,
    output logic [BLK-1:0][BLK-1:0][DATA_W-1:0]                mcu_hold,
    output logic                                               done,
    output logic                                               sel_err
);

    localparam int CNT_W = $clog2(BLK);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_e;

    typedef logic [BLK-1:0][BLK-1:0][DATA_W-1:0] mcu_t;

    state_e            state_q, state_d;
    mcu_t              hold_q, hold_d;
    logic              col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              sel_err_q, sel_err_d;

    logic accept;
    logic sel_ok;
    logic beat_xfer;
    logic at_last;

    assign accept    = req_valid & req_ready;
    assign sel_ok    = (32'(req_sel) < NUM_MCU);
    assign beat_xfer = out_valid & out_ready;
    assign at_last   = (cnt_q == LAST_BEAT);

    // NOTE: the snapshot is cleared by reset like every other register, so an
    // aborted stream never leaves stale pixels visible on mcu_hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            col_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && sel_ok) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat_xfer && at_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        hold_d    = hold_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;

        if (state_q == S_IDLE && accept) begin
            if (sel_ok) begin
                for (int m = 0; m < NUM_MCU; m++) begin
                    if (32'(req_sel) == 32'(m)) begin
                        hold_d = mcu_in[m];
                    end
                end
                col_d = req_col;
                cnt_d = '0;
            end else begin
                sel_err_d = 1'b1;
            end
        end

        // The counter returns to zero on the final beat so it never wraps in STREAM.
        if (state_q == S_STREAM && beat_xfer) begin
            if (at_last) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        out_valid = (state_q == S_STREAM);
        out_last  = (state_q == S_STREAM) && at_last;
        out_idx   = cnt_q;
        out_data  = '0;
        if (state_q == S_STREAM) begin
            for (int i = 0; i < BLK; i++) begin
                out_data[i] = col_q ? hold_q[i][cnt_q] : hold_q[cnt_q][i];
            end
        end
        mcu_hold = hold_q;
        done     = done_q;
        sel_err  = sel_err_q;
    end

endmodule
